// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : RV64 front end: owns the PC, issues single-outstanding ibus
//             requests and hands {instr, pc} to decode over valid/ready.
//  Revision : 1.0
// ============================================================================

package fetch_pkg;
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;
endpackage

module fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [63:0]            ireq_addr,
    input  logic                   iresp_addr_ok,
    input  logic                   iresp_data_ok,
    input  logic [31:0]            iresp_data,
    output fetch_pkg::fetch_data_t dataF,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]             r_state;
    logic [63:0]            r_pc;
    logic [63:0]            r_req_addr;
    logic                   r_kill;
    logic                   r_out_valid;
    fetch_pkg::fetch_data_t r_data;
    fetch_pkg::fetch_data_t r_hold;

    logic                   w_data_hit;
    logic                   w_load_out;
    logic [63:0]            w_redirect_pc;
    fetch_pkg::fetch_data_t w_word;

    assign w_redirect_pc = {redirect_pc[63:2], 2'b00};
    assign w_word        = {iresp_data, ireq_addr};
    assign w_data_hit    = ((r_state == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                           ((r_state == S_WAIT) && iresp_data_ok);
    assign w_load_out    = !r_out_valid || out_ready;

    // While a killed request is in flight the bus must keep seeing its
    // original address even though the PC already points at the redirect.
    assign ireq_valid = reset && (r_state != S_HOLD);
    assign ireq_addr  = (r_state == S_WAIT) ? r_req_addr : r_pc;
    assign out_valid  = r_out_valid;
    assign dataF      = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_kill      <= 1'b0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_hold      <= '0;
        end else if (redirect_valid) begin
            r_pc        <= w_redirect_pc;
            r_out_valid <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (iresp_addr_ok && !iresp_data_ok) begin
                        r_state    <= S_WAIT;
                        r_req_addr <= r_pc;
                        r_kill     <= 1'b1;
                    end else begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok) begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_REQ: begin
                    if (iresp_addr_ok && !iresp_data_ok) begin
                        r_state    <= S_WAIT;
                        r_req_addr <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok && r_kill) begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_data      <= r_hold;
                        r_out_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
            // Completion of a live request; a stalled output parks the word.
            if (w_data_hit && !r_kill) begin
                r_pc <= r_pc + 64'd4;
                if (w_load_out) begin
                    r_data      <= w_word;
                    r_out_valid <= 1'b1;
                    r_state     <= S_REQ;
                end else begin
                    r_hold      <= w_word;
                    r_state     <= S_HOLD;
                end
            end
        end
    end

endmodule
`default_nettype wire
